// File: rtl/coprocessor_debug_slave_sysclk_mc.sv
// Virtual-JTAG debug slave: synchronises update-IR/DR strobes into clk and queues decoded commands.
// Define DEBUG_SLAVE_CMD_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register is used.
module coprocessor_debug_slave_sysclk_mc #(
  parameter int IR_W        = 2,
  parameter int DR_W        = 38,
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [DR_W-1:0]   sr,
  input  logic              vs_uir,
  input  logic              vs_udr,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [DR_W-1:0]   jdo,
  output logic [IR_W-1:0]   cmd_ir,
  output logic [NUM_CH-1:0] cmd_ch,
  output logic [1:0]        status
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef DEBUG_SLAVE_CMD_FIFO_EN
  localparam int QD = FIFO_DEPTH;
`else
  localparam int QD = 1;
`endif
  localparam int PW = (QD > 1) ? $clog2(QD) : 1;
  localparam int CW = $clog2(QD) + 1;
  localparam int EW = IR_W + CH_W + DR_W;

  logic [SYNC_STAGES-1:0] udr_sync, uir_sync, primed;
  logic                   udr_s, uir_s;
  logic                   udr_prev, uir_prev, udr_arm, uir_arm;
  logic                   udr_edge, uir_edge;
  logic [IR_W-1:0]        ir_q;
  logic                   ovf, bad_ch;

  assign udr_s  = udr_sync[SYNC_STAGES-1];
  assign uir_s  = uir_sync[SYNC_STAGES-1];
  assign status = {ovf, bad_ch};

  // primed marks when the chain output reflects a real sample, so a level
  // that was already high at reset release never arms the detector.
  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync <= '0;
      uir_sync <= '0;
      primed   <= '0;
      udr_prev <= 1'b0;
      uir_prev <= 1'b0;
      udr_arm  <= 1'b0;
      uir_arm  <= 1'b0;
      udr_edge <= 1'b0;
      uir_edge <= 1'b0;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      primed   <= {primed[SYNC_STAGES-2:0], 1'b1};
      udr_prev <= udr_s;
      uir_prev <= uir_s;
      udr_arm  <= udr_arm | (primed[SYNC_STAGES-1] & ~udr_s);
      uir_arm  <= uir_arm | (primed[SYNC_STAGES-1] & ~uir_s);
      udr_edge <= udr_arm & udr_s & ~udr_prev;
      uir_edge <= uir_arm & uir_s & ~uir_prev;
    end
  end

  logic [EW-1:0]     mem [QD];
  logic [PW-1:0]     rd_ptr, wr_ptr, rd_next;
  logic [CW-1:0]     count, count_after_pop, count_next;
  logic [CH_W-1:0]   ch, head_ch;
  logic [DR_W-1:0]   data_m;
  logic [EW-1:0]     entry_in, head;
  logic [NUM_CH-1:0] head_oh;
  logic              ch_ok, full, pop, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QD - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    ch                       = sr[DR_W-1 -: CH_W];
    ch_ok                    = (32'(ch) < 32'(NUM_CH));
    data_m                   = sr;
    data_m[DR_W-1 -: CH_W]   = '0;
    entry_in                 = {ir_q, ch, data_m};
    pop                      = cmd_valid & cmd_ready;
    full                     = (count == CW'(QD));
    push                     = udr_edge & ch_ok & (~full | pop);
    count_after_pop          = count - CW'(pop);
    count_next               = count_after_pop + CW'(push);
    rd_next                  = pop ? ptr_inc(rd_ptr) : rd_ptr;
    // Show-ahead: an entry pushed into an (effectively) empty queue bypasses storage.
    head                     = (count_after_pop == '0) ? entry_in : mem[rd_next];
    head_ch                  = head[DR_W +: CH_W];
    head_oh                  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      head_oh[i] = (head_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q      <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      cmd_valid <= 1'b0;
      jdo       <= '0;
      cmd_ir    <= '0;
      cmd_ch    <= '0;
      ovf       <= 1'b0;
      bad_ch    <= 1'b0;
    end else begin
      if (uir_edge) ir_q <= ir_in;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr    <= rd_next;
      count     <= count_next;
      cmd_valid <= (count_next != '0);
      if (count_next != '0) begin
        jdo    <= head[DR_W-1:0];
        cmd_ir <= head[EW-1 -: IR_W];
        cmd_ch <= head_oh;
      end else begin
        cmd_ch <= '0;
      end
      // Flag clear on uir_edge wins over any set in the same cycle.
      if (uir_edge) begin
        ovf    <= 1'b0;
        bad_ch <= 1'b0;
      end else if (udr_edge) begin
        if (!ch_ok) bad_ch <= 1'b1;
        else if (full && !pop) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: doc/coprocessor_debug_slave_sysclk_mc.md
COPROCESSOR_DEBUG_SLAVE_SYSCLK_MC -- requirements
Module: coprocessor_debug_slave_sysclk_mc

Interface
REQ-001 Parameter IR_W, default 2: instruction register width.
REQ-002 Parameter DR_W, default 38: data register width; legal range 8..64.
REQ-003 Parameter NUM_CH, default 4: debug channels (cores); CH_W = max(1, clog2(NUM_CH)).
REQ-004 Parameter SYNC_STAGES, default 2: synchroniser depth; legal range 2..4.
REQ-005 Parameter FIFO_DEPTH, default 4: command queue depth, power of two, 2..16.
REQ-006 Port clk, input, 1: the single clock; every flop is on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port ir_in, input, IR_W: virtual JTAG IR value; quasi-static, stable while vs_uir is high.
REQ-009 Port sr, input, DR_W: tck-domain shift register; stable while vs_udr is high.
REQ-010 Ports vs_uir and vs_udr, input, 1 each: asynchronous update-IR and update-DR levels, each held high for at least SYNC_STAGES+1 clk periods.
REQ-011 Port cmd_valid, output, 1: head command available.
REQ-012 Port cmd_ready, input, 1: consumer accepts the head when cmd_valid=1.
REQ-013 Port jdo, output, DR_W: head command data, sr with bits [DR_W-1 -: CH_W] forced to 0.
REQ-014 Port cmd_ir, output, IR_W: IR value latched for the head command.
REQ-015 Port cmd_ch, output, NUM_CH: one-hot target channel of the head command.
REQ-016 Port status, output, 2: {ovf, bad_ch} sticky flags.

Function
REQ-017 vs_udr and vs_uir each SHALL pass through a SYNC_STAGES flop chain followed by a rising-edge detector (udr_edge, uir_edge); each edge is a one-cycle pulse.
REQ-018 Edge detectors SHALL be armed only after their synchronised input has been sampled low once since reset; a level that is high at reset release produces no edge.
REQ-019 On uir_edge, ir_q SHALL load ir_in, and ovf and bad_ch SHALL clear.
REQ-020 On udr_edge, ch = sr[DR_W-1 -: CH_W]; if ch >= NUM_CH the command SHALL be dropped and bad_ch set.
REQ-021 Otherwise, {ir_q, ch, sr} SHALL be pushed to the queue; if the queue is full and no pop occurs that cycle, the command SHALL be dropped and ovf set.
REQ-022 Simultaneous udr_edge and uir_edge: the push SHALL use the old ir_q, and the flag clear SHALL take priority over a flag set in that cycle.
REQ-023 Pop occurs when cmd_valid and cmd_ready are both 1; a simultaneous push and pop on a full queue SHALL succeed without ovf.
REQ-024 The queue SHALL be show-ahead: jdo, cmd_ir and cmd_ch SHALL be registered and SHALL remain stable while cmd_valid=1 and cmd_ready=0.
REQ-025 Latency, empty queue: cmd_valid SHALL rise on the (SYNC_STAGES+2)th clk edge after the first edge that samples vs_udr high.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter (clog2(FIFO_DEPTH)+1 bits) SHALL never exceed FIFO_DEPTH or go below 0.
REQ-027 When cmd_valid=0, cmd_ch SHALL be 0; jdo and cmd_ir hold their last values.

Reset
REQ-028 While reset=1, the following SHALL be cleared at the next clk edge: synchronisers, edge arms, ir_q, pointers, occupancy, cmd_valid, jdo, cmd_ir, cmd_ch and status.
REQ-029 Reset asserted mid-operation SHALL discard all queued commands; a vs_udr pulse overlapping reset SHALL be lost, not deferred.

Configuration
REQ-030 Macro DEBUG_SLAVE_CMD_FIFO_EN defined: the queue is FIFO_DEPTH entries as specified above.
REQ-031 Macro DEBUG_SLAVE_CMD_FIFO_EN undefined: FIFO_DEPTH SHALL be ignored and a single holding register used; a push while it is full and not popping SHALL set ovf; all ports are unchanged.

Verification
REQ-032 Defaults, ir_in=2'b01 then vs_uir pulse, then vs_udr pulse with sr[37:36]=2'b10 -> cmd_valid at edge SYNC_STAGES+2, cmd_ir=01, cmd_ch=4'b0100, jdo[37:36]=00.
REQ-033 NUM_CH=3, pulse with channel field=3 -> no cmd_valid, status=2'b01; a later vs_uir pulse -> status=2'b00.
REQ-034 cmd_ready=0, 5 udr pulses with FIFO enabled -> 4 entries in order, ovf=1; drain with cmd_ready=1 -> 4 pops, then cmd_valid=0.
REQ-035 Full queue, cmd_ready=1 coincident with udr_edge -> occupancy remains 4, ovf=0, order preserved.
REQ-036 vs_udr held high across reset release -> no command; the first subsequent 0->1 pulse -> exactly one command.
REQ-037 Macro undefined, 2 pulses with cmd_ready=0 -> first command held, ovf=1.
